// File: rtl/nibble_sel_pipe_if.sv
// Handshake/bus bundle for nibble_sel_pipe.
// The master drives transactions in and consumes results; the slave is the pipeline.
interface nibble_sel_pipe_if #(
    parameter int NIB_W = 4,
    parameter int N_NIB = 8,
    parameter int N_SEL = 4
);
    localparam int SEL_W = $clog2(N_NIB);
    localparam int IDX_W = $clog2(N_SEL);

    logic                     IN_VALID;
    logic                     IN_READY;
    logic [N_NIB*NIB_W-1:0]   DATA_A;
    logic [N_NIB*NIB_W-1:0]   DATA_B;
    logic [N_SEL*SEL_W-1:0]   SEL_A;
    logic [N_SEL*SEL_W-1:0]   SEL_B;
    logic [N_SEL-1:0]         SEL_AB;
    logic                     MODE;
    logic                     OUT_VALID;
    logic                     OUT_READY;
    logic [NIB_W-1:0]         DATA_OUT;
    logic [IDX_W-1:0]         OUT_IDX;

    modport master (
        output IN_VALID, DATA_A, DATA_B, SEL_A, SEL_B, SEL_AB, MODE, OUT_READY,
        input  IN_READY, OUT_VALID, DATA_OUT, OUT_IDX
    );

    modport slave (
        input  IN_VALID, DATA_A, DATA_B, SEL_A, SEL_B, SEL_AB, MODE, OUT_READY,
        output IN_READY, OUT_VALID, DATA_OUT, OUT_IDX
    );
endinterface

// File: rtl/nibble_sel_pipe.sv
// nibble_sel_pipe: 2-stage max/min nibble selector with valid/ready on both sides.
// Stage 1 latches the N_SEL candidate nibbles and MODE; stage 2 reduces them through
// a compare tree (lowest slot wins ties) and registers the result.
// Optional: define NIBBLE_SEL_STATS_EN to add saturating IN_CNT/OUT_CNT transfer counters.
module nibble_sel_pipe #(
    parameter int NIB_W = 4,
    parameter int N_NIB = 8,
    parameter int N_SEL = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    nibble_sel_pipe_if.slave   bus
`ifdef NIBBLE_SEL_STATS_EN
    ,
    output logic [15:0]        IN_CNT,
    output logic [15:0]        OUT_CNT
`endif
);
    localparam int SEL_W = $clog2(N_NIB);
    localparam int IDX_W = $clog2(N_SEL);
    localparam int NODES = 2 * N_SEL - 1;

    logic                 s1_valid_q;
    logic [NIB_W-1:0]     cand_q [N_SEL];
    logic [NIB_W-1:0]     cand_d [N_SEL];
    logic                 mode_q;
    logic                 out_valid_q;
    logic [NIB_W-1:0]     out_data_q;
    logic [IDX_W-1:0]     out_idx_q;

    logic                 s2_ready;
    logic                 in_ready;
    logic                 in_fire;

    // Heap-ordered reduce tree: leaves at N_SEL-1+i, root at 0. The left child always
    // covers the lower slot indices, so preferring it on equality gives lowest-slot ties.
    logic [NIB_W-1:0]     node_val [NODES];
    logic [IDX_W-1:0]     node_idx [NODES];

    assign s2_ready      = !out_valid_q || bus.OUT_READY;
    assign in_ready      = !s1_valid_q || s2_ready;
    assign in_fire       = bus.IN_VALID && in_ready;

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.DATA_OUT  = out_data_q;
    assign bus.OUT_IDX   = out_idx_q;

    // Pick each slot's candidate nibble from A or B using that slot's own index
    always_comb begin
        for (int i = 0; i < N_SEL; i++) begin
            if (bus.SEL_AB[i])
                cand_d[i] = bus.DATA_B[int'(bus.SEL_B[i*SEL_W +: SEL_W])*NIB_W +: NIB_W];
            else
                cand_d[i] = bus.DATA_A[int'(bus.SEL_A[i*SEL_W +: SEL_W])*NIB_W +: NIB_W];
        end
    end

    // Compare/reduce tree over the stage-1 candidates
    always_comb begin
        for (int i = 0; i < N_SEL; i++) begin
            node_val[N_SEL-1+i] = cand_q[i];
            node_idx[N_SEL-1+i] = IDX_W'(i);
        end
        for (int n = N_SEL - 2; n >= 0; n--) begin
            // Right subtree (higher slots) wins only on a strict improvement
            if (mode_q ? (node_val[2*n+2] < node_val[2*n+1])
                       : (node_val[2*n+2] > node_val[2*n+1])) begin
                node_val[n] = node_val[2*n+2];
                node_idx[n] = node_idx[2*n+2];
            end else begin
                node_val[n] = node_val[2*n+1];
                node_idx[n] = node_idx[2*n+1];
            end
        end
    end

    // Pipeline registers: stage 2 advances whenever the output slot is free or draining,
    // and stage 1 refills on the same edge it empties
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_valid_q  <= 1'b0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            for (int i = 0; i < N_SEL; i++) cand_q[i] <= '0;
        end else begin
            if (s2_ready) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= node_val[0];
                    out_idx_q  <= node_idx[0];
                end
            end
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                cand_q     <= cand_d;
                mode_q     <= bus.MODE;
            end else if (s2_ready) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

`ifdef NIBBLE_SEL_STATS_EN
    logic        out_fire;
    logic [15:0] in_cnt_q;
    logic [15:0] out_cnt_q;

    assign out_fire = out_valid_q && bus.OUT_READY;
    assign IN_CNT   = in_cnt_q;
    assign OUT_CNT  = out_cnt_q;

    // Saturating transfer counters on both handshakes
    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (in_fire && in_cnt_q != 16'hFFFF)   in_cnt_q  <= in_cnt_q + 16'd1;
            if (out_fire && out_cnt_q != 16'hFFFF) out_cnt_q <= out_cnt_q + 16'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_nibble_sel_pipe.sv
// Bench for nibble_sel_pipe: directed checks on the default configuration and a
// randomized stream with random backpressure on an 8-bit/4-nibble/8-slot variant,
// compared against a linear-scan reference model.
module tb_nibble_sel_pipe;
    localparam int NTX = 1000;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    nibble_sel_pipe_if #(.NIB_W(4), .N_NIB(8), .N_SEL(4)) b0 ();
    nibble_sel_pipe_if #(.NIB_W(8), .N_NIB(4), .N_SEL(8)) b1 ();

`ifdef NIBBLE_SEL_STATS_EN
    logic [15:0] in_cnt0, out_cnt0, in_cnt1, out_cnt1;
`endif

    nibble_sel_pipe #(.NIB_W(4), .N_NIB(8), .N_SEL(4)) u_dut0 (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (b0)
`ifdef NIBBLE_SEL_STATS_EN
        ,
        .IN_CNT  (in_cnt0),
        .OUT_CNT (out_cnt0)
`endif
    );

    nibble_sel_pipe #(.NIB_W(8), .N_NIB(4), .N_SEL(8)) u_dut1 (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (b1)
`ifdef NIBBLE_SEL_STATS_EN
        ,
        .IN_CNT  (in_cnt1),
        .OUT_CNT (out_cnt1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: scan slots in order, replace only on strict improvement
    function automatic void ref_sel(input int nw, input int nn, input int ns,
                                    input logic [63:0] da, input logic [63:0] db,
                                    input logic [63:0] sa, input logic [63:0] sb,
                                    input logic [63:0] ab, input logic mode,
                                    output int best, output int bidx);
        int sw;
        sw   = $clog2(nn);
        best = 0;
        bidx = 0;
        for (int i = 0; i < ns; i++) begin
            logic [63:0] w;
            logic [63:0] s;
            int k;
            int c;
            w = ab[i] ? db : da;
            s = ab[i] ? sb : sa;
            k = int'((s >> (i * sw)) & ((64'd1 << sw) - 64'd1));
            c = int'((w >> (k * nw)) & ((64'd1 << nw) - 64'd1));
            if (i == 0 || (mode ? (c < best) : (c > best))) begin
                best = c;
                bidx = i;
            end
        end
    endfunction

    task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [11:0] sa,
                          input logic [11:0] sb, input logic [3:0] ab, input logic m);
        b0.DATA_A   = a;
        b0.DATA_B   = b;
        b0.SEL_A    = sa;
        b0.SEL_B    = sb;
        b0.SEL_AB   = ab;
        b0.MODE     = m;
        b0.IN_VALID = 1'b1;
    endtask

    // One transaction on DUT0 with OUT_READY high; checks exact 2-cycle latency
    task automatic single0(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [11:0] sa, input logic [11:0] sb, input logic [3:0] ab,
                           input logic m, input int exp_d, input int exp_i);
        @(posedge CLK); #1;
        drive0(a, b, sa, sb, ab, m);
        @(negedge CLK);
        chk({tag, "_in_ready"}, 64'(b0.IN_READY), 64'd1);
        @(posedge CLK); #1;
        b0.IN_VALID = 1'b0;
        @(negedge CLK);
        chk({tag, "_early_valid"}, 64'(b0.OUT_VALID), 64'd0);
        @(negedge CLK);
        chk({tag, "_valid"}, 64'(b0.OUT_VALID), 64'd1);
        chk({tag, "_data"}, 64'(b0.DATA_OUT), 64'(exp_d));
        chk({tag, "_idx"}, 64'(b0.OUT_IDX), 64'(exp_i));
    endtask

    typedef struct {
        int d;
        int i;
    } res_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t q[$];
        res_t r;
        int   sent, got, cyc, in_x, out_x, ed, ei;
        logic acc;

        RESET = 1'b1;
        b0.IN_VALID = 1'b0; b0.OUT_READY = 1'b0; b0.DATA_A = '0; b0.DATA_B = '0;
        b0.SEL_A = '0; b0.SEL_B = '0; b0.SEL_AB = '0; b0.MODE = 1'b0;
        b1.IN_VALID = 1'b0; b1.OUT_READY = 1'b0; b1.DATA_A = '0; b1.DATA_B = '0;
        b1.SEL_A = '0; b1.SEL_B = '0; b1.SEL_AB = '0; b1.MODE = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        b0.OUT_READY = 1'b1;
        @(negedge CLK);
        chk("rst_out_valid", 64'(b0.OUT_VALID), 64'd0);
        chk("rst_data_out", 64'(b0.DATA_OUT), 64'd0);
        chk("rst_out_idx", 64'(b0.OUT_IDX), 64'd0);
        chk("rst_in_ready", 64'(b0.IN_READY), 64'd1);

        // Max, min, and all-equal ties in both modes
        single0("t2_max", 32'h01234567, 32'h89ABCDEF, 12'hF11, 12'hF11, 4'hA, 1'b0, 'hD, 1);
        single0("t3_min", 32'h01234567, 32'h89ABCDEF, 12'hF11, 12'hF11, 4'hA, 1'b1, 'h3, 2);
        single0("t3_tie_min", 32'h01234567, 32'h89ABCDEF, 12'h000, 12'hF11, 4'h0, 1'b1, 'h7, 0);
        single0("t3_tie_max", 32'h01234567, 32'h89ABCDEF, 12'h000, 12'hF11, 4'h0, 1'b0, 'h7, 0);

        // Backpressure: 3 back-to-back with OUT_READY low
        @(posedge CLK); #1;
        b0.OUT_READY = 1'b0;
        drive0(32'h01234567, 32'h89ABCDEF, 12'hF11, 12'hF11, 4'hA, 1'b0);
        @(posedge CLK); #1;
        drive0(32'h01234567, 32'h89ABCDEF, 12'hF11, 12'hF11, 4'hA, 1'b1);
        @(posedge CLK); #1;
        drive0(32'h01234567, 32'h89ABCDEF, 12'h000, 12'hF11, 4'h0, 1'b0);
        @(negedge CLK);
        chk("t4_full_in_ready", 64'(b0.IN_READY), 64'd0);
        chk("t4_full_valid", 64'(b0.OUT_VALID), 64'd1);
        chk("t4_full_data", 64'(b0.DATA_OUT), 64'hD);
        chk("t4_full_idx", 64'(b0.OUT_IDX), 64'd1);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("t4_hold_data", 64'(b0.DATA_OUT), 64'hD);
        chk("t4_hold_valid", 64'(b0.OUT_VALID), 64'd1);
        chk("t4_hold_in_ready", 64'(b0.IN_READY), 64'd0);
        b0.OUT_READY = 1'b1;
        #1;
        chk("t4_release_in_ready", 64'(b0.IN_READY), 64'd1);
        @(posedge CLK); #1;
        b0.IN_VALID = 1'b0;
        @(negedge CLK);
        chk("t4_r1_valid", 64'(b0.OUT_VALID), 64'd1);
        chk("t4_r1_data", 64'(b0.DATA_OUT), 64'h3);
        chk("t4_r1_idx", 64'(b0.OUT_IDX), 64'd2);
        @(negedge CLK);
        chk("t4_r2_valid", 64'(b0.OUT_VALID), 64'd1);
        chk("t4_r2_data", 64'(b0.DATA_OUT), 64'h7);
        chk("t4_r2_idx", 64'(b0.OUT_IDX), 64'd0);
        @(negedge CLK);
        chk("t4_drained", 64'(b0.OUT_VALID), 64'd0);

        // Reset with two in flight, plus a handshake offered during reset
        @(posedge CLK); #1;
        b0.OUT_READY = 1'b0;
        drive0(32'h01234567, 32'h89ABCDEF, 12'hF11, 12'hF11, 4'hA, 1'b0);
        @(posedge CLK); #1;
        drive0(32'h01234567, 32'h89ABCDEF, 12'hF11, 12'hF11, 4'hA, 1'b1);
        @(posedge CLK); #1;
        b0.IN_VALID = 1'b0;
        @(negedge CLK);
        chk("t5_inflight_valid", 64'(b0.OUT_VALID), 64'd1);
        chk("t5_inflight_in_ready", 64'(b0.IN_READY), 64'd0);
        RESET = 1'b1;
        b0.OUT_READY = 1'b1;
        b0.IN_VALID = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        b0.IN_VALID = 1'b0;
        @(negedge CLK);
        chk("t5_rst_valid", 64'(b0.OUT_VALID), 64'd0);
        chk("t5_rst_data", 64'(b0.DATA_OUT), 64'd0);
        chk("t5_rst_idx", 64'(b0.OUT_IDX), 64'd0);
        chk("t5_rst_in_ready", 64'(b0.IN_READY), 64'd1);
`ifdef NIBBLE_SEL_STATS_EN
        chk("t5_in_cnt", 64'(in_cnt0), 64'd0);
        chk("t5_out_cnt", 64'(out_cnt0), 64'd0);
`endif
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("t5_no_ghost", 64'(b0.OUT_VALID), 64'd0);
        end

        // Randomized stream on the variant with random backpressure
        sent = 0; got = 0; cyc = 0; in_x = 0; out_x = 0; acc = 1'b0;
        while (got < NTX && cyc < 20000) begin
            @(posedge CLK); #1;
            cyc++;
            if (acc) b1.IN_VALID = 1'b0;
            acc = 1'b0;
            if (!b1.IN_VALID && sent < NTX && $urandom_range(3) != 0) begin
                b1.DATA_A = $urandom;
                b1.DATA_B = $urandom;
                if ($urandom_range(1) == 1) begin
                    b1.DATA_A &= 32'h03030303;
                    b1.DATA_B &= 32'h03030303;
                end
                b1.SEL_A    = 16'($urandom);
                b1.SEL_B    = 16'($urandom);
                b1.SEL_AB   = 8'($urandom);
                b1.MODE     = 1'($urandom);
                b1.IN_VALID = 1'b1;
            end
            b1.OUT_READY = ($urandom_range(3) != 0);
            @(negedge CLK);
            if (b1.IN_VALID && b1.IN_READY) begin
                ref_sel(8, 4, 8, 64'(b1.DATA_A), 64'(b1.DATA_B), 64'(b1.SEL_A), 64'(b1.SEL_B),
                        64'(b1.SEL_AB), b1.MODE, ed, ei);
                r.d = ed;
                r.i = ei;
                q.push_back(r);
                sent++;
                in_x++;
                acc = 1'b1;
            end
            if (b1.OUT_VALID && b1.OUT_READY) begin
                out_x++;
                got++;
                chk("t6_expected_pending", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    r = q.pop_front();
                    chk("t6_data", 64'(b1.DATA_OUT), 64'(r.d));
                    chk("t6_idx", 64'(b1.OUT_IDX), 64'(r.i));
                end
            end
        end
        chk("t6_result_count", 64'(got), 64'(NTX));
        chk("t6_queue_empty", 64'(q.size()), 64'd0);
`ifdef NIBBLE_SEL_STATS_EN
        @(negedge CLK);
        chk("t6_in_cnt", 64'(in_cnt1), 64'(in_x));
        chk("t6_out_cnt", 64'(out_cnt1), 64'(out_x));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
